fetch_unit: RTL and testbench

- PC/IR responder for the SISC controller's fetch-side control outputs: `pc_rst`, `pc_write`, `pc_sel`, `br_sel`, `ir_load`.
- Owns the program counter and the instruction register.
- Runs the instruction fetch to instruction memory over a req/ack handshake.
- Returns `fetch_busy` so the controller can hold in fetch until the IR is valid.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter, instruction register and instruction-fetch handshake
// for the SISC controller's fetch side.
//
// state | meaning
// IDLE  | no fetch outstanding, waiting for ir_load
// REQ   | imem_req held with a frozen address until imem_ack
// DONE  | one cycle: IR freshly loaded, ir_valid pulses, may restart fetch
module fetch_unit #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    input  logic [PC_W-1:0]    imm,
    fetch_unit_if.master       imem,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    output logic               fetch_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    addr_q;
    logic [INSTR_W-1:0] ir_q;
    logic               start_fetch;
    logic               take_ack;

    // PC sequencing is independent of the fetch FSM; wrap-around is silent
    always_comb begin
        pc_d = pc_q;
        if (pc_rst) begin
            pc_d = '0;
        end else if (pc_write) begin
            if (!pc_sel) begin
                pc_d = pc_q + PC_W'(1);
            end else if (br_sel) begin
                pc_d = imm;
            end else begin
                pc_d = pc_q + imm;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        start_fetch = 1'b0;
        take_ack    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (ir_load) begin
                    start_fetch = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    take_ack = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            // Address captures the pre-update PC so fetch and PC advance can overlap
            if (start_fetch) begin
                addr_q <= pc_q;
            end
            if (take_ack) begin
                ir_q <= imem.imem_rdata;
            end
        end
    end

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = addr_q;
    assign fetch_busy     = (state_q == REQ);
    assign ir_valid       = (state_q == DONE);
    assign pc_out         = pc_q;
    assign ir_out         = ir_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared each cycle against a transaction-level reference model.
module tb_fetch_unit;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst_f = 1'b0;
    logic               pc_rst = 1'b0;
    logic               pc_write = 1'b0;
    logic               pc_sel = 1'b0;
    logic               br_sel = 1'b0;
    logic               ir_load = 1'b0;
    logic [PC_W-1:0]    imm = '0;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               fetch_busy;

    int errors = 0;
    int checks = 0;

    // Reference model: a fetch is either outstanding or not
    logic [PC_W-1:0]    m_pc = '0;
    logic [PC_W-1:0]    m_addr = '0;
    logic [INSTR_W-1:0] m_ir = '0;
    logic               m_active = 1'b0;
    logic               m_valid = 1'b0;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .ir_load    (ir_load),
        .imm        (imm),
        .imem       (bus.master),
        .pc_out     (pc_out),
        .ir_out     (ir_out),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model consumes the inputs that the edge sees
    task automatic tick();
        if (rst_f) begin
            m_pc = '0; m_addr = '0; m_ir = '0; m_active = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_active && bus.imem_ack) begin
                m_ir = bus.imem_rdata; m_active = 1'b0; m_valid = 1'b1;
            end else if (!m_active && ir_load) begin
                m_addr = m_pc; m_active = 1'b1;
            end
            if (pc_rst) m_pc = '0;
            else if (pc_write) begin
                if (!pc_sel) m_pc = m_pc + 16'd1;
                else if (br_sel) m_pc = imm;
                else m_pc = m_pc + imm;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst_f = 0; pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
        imm = '0; bus.imem_ack = 0; bus.imem_rdata = '0;
    endtask

    task automatic set_pc(input logic [PC_W-1:0] v);
        pc_write = 1; pc_sel = 1; br_sel = 1; imm = v;
        tick();
        pc_write = 0; pc_sel = 0; br_sel = 0; imm = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_f = 1;
        tick();
        tick();
        rst_f = 0;
        checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
        checks++; if (ir_out !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=00000000", ir_out); end
        checks++; if (bus.imem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0000", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ir_valid); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", fetch_busy); end
    endtask

    task automatic test_basic_fetch();
        ir_load = 1; pc_write = 1; pc_sel = 0;
        tick();
        ir_load = 0; pc_write = 0;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL basic_req got=%b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL basic_addr got=%h exp=0000", bus.imem_addr); end
        checks++; if (pc_out !== 16'h0001) begin errors++; $display("FAIL basic_pc got=%h exp=0001", pc_out); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", ir_valid); end
        bus.imem_ack = 1; bus.imem_rdata = 32'h12345678;
        tick();
        bus.imem_ack = 0; bus.imem_rdata = '0;
        checks++; if (ir_out !== 32'h12345678) begin errors++; $display("FAIL basic_ir got=%h exp=12345678", ir_out); end
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", ir_valid); end
        checks++; if (bus.imem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL basic_done_req got=%b/%b exp=0/0", bus.imem_req, fetch_busy); end
        tick();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got=%b exp=0", ir_valid); end
    endtask

    task automatic test_wait_states();
        int req_cycles = 0;
        set_pc(16'h0005);
        ir_load = 1;
        tick();
        ir_load = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.imem_req === 1'b1) req_cycles++;
            checks++; if (bus.imem_addr !== 16'h0005) begin errors++; $display("FAIL wait_addr cyc=%0d got=%h exp=0005", i, bus.imem_addr); end
            checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL wait_busy cyc=%0d got=%b exp=1", i, fetch_busy); end
            ir_load = (i == 1);
            pc_write = (i == 2);
            bus.imem_ack = (i == 3);
            bus.imem_rdata = 32'hCAFE0005;
            tick();
            ir_load = 0; pc_write = 0;
        end
        bus.imem_ack = 0;
        checks++; if (req_cycles != 4) begin errors++; $display("FAIL wait_req_cycles got=%0d exp=4", req_cycles); end
        checks++; if (ir_out !== 32'hCAFE0005 || ir_valid !== 1'b1) begin errors++; $display("FAIL wait_ir got=%h/%b exp=cafe0005/1", ir_out, ir_valid); end
        checks++; if (pc_out !== 16'h0006) begin errors++; $display("FAIL wait_pc got=%h exp=0006", pc_out); end
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait_extra_req got=%b exp=0", bus.imem_req); end
    endtask

    task automatic test_pc_arith();
        set_pc(16'h0010);
        pc_write = 1; pc_sel = 1; br_sel = 0; imm = 16'hFFFC;
        tick();
        checks++; if (pc_out !== 16'h000C) begin errors++; $display("FAIL pc_rel got=%h exp=000c", pc_out); end
        br_sel = 1; imm = 16'h0040;
        tick();
        checks++; if (pc_out !== 16'h0040) begin errors++; $display("FAIL pc_abs got=%h exp=0040", pc_out); end
        imm = 16'hFFFF;
        tick();
        pc_sel = 0;
        tick();
        pc_write = 0;
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL pc_wrap got=%h exp=0000", pc_out); end
        set_pc(16'h0002);
        pc_write = 1; pc_sel = 1; br_sel = 0; imm = 16'hFFFE;
        tick();
        pc_write = 0; pc_sel = 0;
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL pc_rel_wrap got=%h exp=0000", pc_out); end
    endtask

    task automatic test_priority();
        set_pc(16'h0021);
        pc_rst = 1; pc_write = 1; pc_sel = 1; br_sel = 1; imm = 16'h0033;
        tick();
        pc_rst = 0;
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL prio_pc_rst got=%h exp=0000", pc_out); end
        set_pc(16'h0077);
        rst_f = 1; pc_write = 1; pc_sel = 0;
        tick();
        rst_f = 0; pc_write = 0;
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL prio_rst_f got=%h exp=0000", pc_out); end
    endtask

    task automatic test_reset_abort();
        set_pc(16'h0009);
        ir_load = 1;
        tick();
        ir_load = 0;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL abort_req_pre got=%b exp=1", bus.imem_req); end
        rst_f = 1;
        tick();
        rst_f = 0;
        bus.imem_ack = 1; bus.imem_rdata = 32'hDEADBEEF;
        tick();
        bus.imem_ack = 0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL abort_req got=%b exp=0", bus.imem_req); end
        checks++; if (ir_out !== 32'h0) begin errors++; $display("FAIL abort_ir got=%h exp=00000000", ir_out); end
        checks++; if (ir_valid !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL abort_flags got=%b/%b exp=0/0", ir_valid, fetch_busy); end
    endtask

    task automatic test_back_to_back();
        set_pc(16'h0100);
        ir_load = 1; pc_write = 1;
        tick();
        ir_load = 0; pc_write = 0;
        bus.imem_ack = 1; bus.imem_rdata = 32'h11223344;
        tick();
        bus.imem_ack = 0;
        tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'hAAAAAAAA;
        tick();
        bus.imem_ack = 0;
        checks++; if (ir_out !== 32'h11223344) begin errors++; $display("FAIL stray_ack_ir got=%h exp=11223344", ir_out); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL stray_ack_valid got=%b exp=0", ir_valid); end
        ir_load = 1; pc_write = 1;
        tick();
        ir_load = 0; pc_write = 0;
        bus.imem_ack = 1; bus.imem_rdata = 32'h55667788;
        tick();
        bus.imem_ack = 0;
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got=%b exp=1", ir_valid); end
        ir_load = 1; pc_write = 1;
        tick();
        ir_load = 0; pc_write = 0;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req got=%b exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 16'h0102) begin errors++; $display("FAIL b2b_addr got=%h exp=0102", bus.imem_addr); end
        bus.imem_ack = 1; bus.imem_rdata = 32'h99AABBCC;
        tick();
        bus.imem_ack = 0;
        checks++; if (ir_out !== 32'h99AABBCC) begin errors++; $display("FAIL b2b_ir got=%h exp=99aabbcc", ir_out); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst_f    = ($urandom_range(0, 59) == 0);
            pc_rst   = ($urandom_range(0, 19) == 0);
            pc_write = $urandom_range(0, 1);
            pc_sel   = $urandom_range(0, 1);
            br_sel   = $urandom_range(0, 1);
            ir_load  = ($urandom_range(0, 2) == 0);
            imm      = PC_W'($urandom);
            bus.imem_rdata = $urandom;
            if (bus.imem_req === 1'b1) bus.imem_ack = ($urandom_range(0, 2) == 0);
            else bus.imem_ack = ($urandom_range(0, 7) == 0);
            tick();
            checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc_out, m_pc); end
            checks++; if (ir_out !== m_ir) begin errors++; $display("FAIL rnd_ir n=%0d got=%h exp=%h", n, ir_out, m_ir); end
            checks++; if (bus.imem_req !== m_active || fetch_busy !== m_active) begin errors++; $display("FAIL rnd_req n=%0d got=%b/%b exp=%b", n, bus.imem_req, fetch_busy, m_active); end
            checks++; if (ir_valid !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, ir_valid, m_valid); end
            checks++; if (bus.imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.imem_addr, m_addr); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_pc_arith();
        test_priority();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
